// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity modes, receiver state encoding and baud divider helper
package uart_pkg;

   // Parity modes selected by the PARITY parameter
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Receiver states; every state other than ST_IDLE counts as busy
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } uart_state_e;

   // Clocks per 16x oversampling tick, rounded to nearest, never below 1
   function automatic int calc_div(input int clk_freq, input int baud_rate);
      longint denom;
      longint div;
      denom = longint'(baud_rate) * 64'sd16;
      if (denom < 64'sd1) begin
         denom = 64'sd1;
      end
      div = (longint'(clk_freq) + denom / 64'sd2) / denom;
      if (div < 64'sd1) begin
         div = 64'sd1;
      end
      return int'(div);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - enable-gated divider producing one-cycle oversampling ticks
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count only while enabled; dropping en parks the counter at zero so the
   // first tick after enable lands a full DIV clocks later
   always_comb begin
      cnt_d = cnt_q;
      if (!en || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Divider count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable-format 16x oversampling UART receiver with valid/ready output
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int         DIV       = calc_div(CLK_FREQ, BAUD_RATE);
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   logic                 sync1_q;
   logic                 sync2_q;
   logic                 rx_sync;
   logic                 tick;
   logic                 decide;
   logic                 maj;
   logic                 par_exp;
   logic                 load;

   uart_state_e          state_q,    state_d;
   logic [3:0]           tick_cnt_q, tick_cnt_d;
   logic                 s7_q,       s7_d;
   logic                 s8_q,       s8_d;
   logic [2:0]           bit_cnt_q,  bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic                 frm_perr_q, frm_perr_d;
   logic                 frm_ferr_q, frm_ferr_d;
   logic [3:0]           high_cnt_q, high_cnt_d;

   logic [DATA_BITS-1:0] out_data_q;
   logic                 out_valid_q;
   logic                 out_perr_q;
   logic                 out_ferr_q;
   logic                 out_ovr_q;

   // Two-flop synchroniser; resets to the idle-high line level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
      end
   end

   assign rx_sync = sync2_q;
   assign rx_busy = (state_q != ST_IDLE);

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (rx_busy),
      .tick (tick)
   );

   assign decide  = tick && (tick_cnt_q == 4'd9);
   assign maj     = (s7_q & s8_q) | (s7_q & rx_sync) | (s8_q & rx_sync);
   assign par_exp = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);

   // Next-state logic: tick numbering, mid-bit sampling, frame assembly and break wait
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      s7_d       = s7_q;
      s8_d       = s8_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      frm_perr_d = frm_perr_q;
      frm_ferr_d = frm_ferr_q;
      high_cnt_d = high_cnt_q;
      load       = 1'b0;

      if (tick) begin
         tick_cnt_d = tick_cnt_q + 4'd1;
         if (tick_cnt_q == 4'd7) begin
            s7_d = rx_sync;
         end
         if (tick_cnt_q == 4'd8) begin
            s8_d = rx_sync;
         end
      end

      case (state_q)
         ST_IDLE: begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            frm_perr_d = 1'b0;
            frm_ferr_d = 1'b0;
            high_cnt_d = '0;
            if (!rx_sync) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            // A high majority means the low level was a glitch, not a start bit
            if (decide) begin
               state_d = maj ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (decide) begin
               shift_d = {maj, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (decide) begin
               frm_perr_d = maj ^ par_exp;
               state_d    = ST_STOP;
            end
         end
         ST_STOP: begin
            if (decide) begin
               frm_ferr_d = frm_ferr_q | ~maj;
               if (stop_cnt_q == LAST_STOP) begin
                  load    = 1'b1;
                  state_d = frm_ferr_d ? ST_WAIT_IDLE : ST_IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         ST_WAIT_IDLE: begin
            // A line held low (break) must return high for 16 straight ticks
            if (!rx_sync) begin
               high_cnt_d = '0;
            end else if (tick) begin
               if (high_cnt_q == 4'd15) begin
                  state_d = ST_IDLE;
               end else begin
                  high_cnt_d = high_cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Receiver state and frame-assembly registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         s7_q       <= 1'b1;
         s8_q       <= 1'b1;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         frm_perr_q <= 1'b0;
         frm_ferr_q <= 1'b0;
         high_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         s7_q       <= s7_d;
         s8_q       <= s8_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         frm_perr_q <= frm_perr_d;
         frm_ferr_q <= frm_ferr_d;
         high_cnt_q <= high_cnt_d;
      end
   end

   // Output holding register; a word arriving onto an unaccepted word is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_perr_q  <= 1'b0;
         out_ferr_q  <= 1'b0;
         out_ovr_q   <= 1'b0;
      end else if (load) begin
         if (!out_valid_q || ready) begin
            out_data_q  <= shift_q;
            out_perr_q  <= frm_perr_q;
            out_ferr_q  <= frm_ferr_d;
            out_valid_q <= 1'b1;
         end else begin
            out_ovr_q <= 1'b1;
         end
      end else if (out_valid_q && ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign data_out   = out_data_q;
   assign valid      = out_valid_q;
   assign parity_err = out_perr_q;
   assign frame_err  = out_ferr_q;
   assign overrun    = out_ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed bench for uart_rx_cfg in 8N1, 7E1 and 8N2 formats
module tb_uart_rx_cfg;

   localparam int CLK_HZ  = 18_432_000;
   localparam int BAUD    = 115200;
   localparam int BIT_CYC = 160;

   logic       clk;
   logic       rst;
   logic       rx_a, rx_b, rx_c;
   logic       ready_a, ready_b, ready_c;
   logic [7:0] data_out_a;
   logic [6:0] data_out_b;
   logic [7:0] data_out_c;
   logic       valid_a, valid_b, valid_c;
   logic       perr_a, perr_b, perr_c;
   logic       ferr_a, ferr_b, ferr_c;
   logic       ovr_a, ovr_b, ovr_c;
   logic       busy_a, busy_b, busy_c;

   int         errors = 0;
   int         checks = 0;

   int         cap_cnt_a = 0, cap_cnt_b = 0, cap_cnt_c = 0;
   int         vcyc_a = 0;
   logic [7:0] cap_data_a = '0, cap_data_b = '0, cap_data_c = '0;
   logic       cap_perr_a = 1'b0, cap_perr_b = 1'b0, cap_perr_c = 1'b0;
   logic       cap_ferr_a = 1'b0, cap_ferr_b = 1'b0, cap_ferr_c = 1'b0;

   int         n0;
   int         v0;

   uart_rx_cfg #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst), .rx(rx_a), .data_out(data_out_a), .valid(valid_a), .ready(ready_a),
      .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .rx_busy(busy_a));

   uart_rx_cfg #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_b (
      .clk(clk), .rst(rst), .rx(rx_b), .data_out(data_out_b), .valid(valid_b), .ready(ready_b),
      .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .rx_busy(busy_b));

   uart_rx_cfg #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
      .clk(clk), .rst(rst), .rx(rx_c), .data_out(data_out_c), .valid(valid_c), .ready(ready_c),
      .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c), .rx_busy(busy_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every accepted word on the falling edge
   always @(negedge clk) begin
      if (valid_a) vcyc_a <= vcyc_a + 1;
      if (valid_a && ready_a) begin
         cap_cnt_a  <= cap_cnt_a + 1;
         cap_data_a <= data_out_a;
         cap_perr_a <= perr_a;
         cap_ferr_a <= ferr_a;
      end
      if (valid_b && ready_b) begin
         cap_cnt_b  <= cap_cnt_b + 1;
         cap_data_b <= {1'b0, data_out_b};
         cap_perr_b <= perr_b;
         cap_ferr_b <= ferr_b;
      end
      if (valid_c && ready_c) begin
         cap_cnt_c  <= cap_cnt_c + 1;
         cap_data_c <= data_out_c;
         cap_perr_c <= perr_c;
         cap_ferr_c <= ferr_c;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_rx(input int sel, input logic v);
      case (sel)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   task automatic drive_bit(input int sel, input logic v);
      set_rx(sel, v);
      repeat (BIT_CYC) @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input logic [7:0] data, input int nbits,
                             input bit par_en, input logic par_bit, input int nstop,
                             input logic [1:0] stops);
      drive_bit(sel, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
      if (par_en) drive_bit(sel, par_bit);
      for (int i = 0; i < nstop; i++) drive_bit(sel, stops[i]);
      set_rx(sel, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
      ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
      repeat (5) @(negedge clk);

      chk("rst_data",  32'(data_out_a), 0);
      chk("rst_valid", 32'(valid_a), 0);
      chk("rst_perr",  32'(perr_a), 0);
      chk("rst_ferr",  32'(ferr_a), 0);
      chk("rst_ovr",   32'(ovr_a), 0);
      chk("rst_busy",  32'(busy_a), 0);

      rst = 1'b0;
      repeat (20) @(negedge clk);

      // 8N1 0xA5 with ready held high
      n0 = cap_cnt_a; v0 = vcyc_a;
      send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1, 2'b11);
      repeat (40) @(negedge clk);
      chk("a5_count", cap_cnt_a - n0, 1);
      chk("a5_vcyc",  vcyc_a - v0, 1);
      chk("a5_data",  32'(cap_data_a), 32'hA5);
      chk("a5_perr",  32'(cap_perr_a), 0);
      chk("a5_ferr",  32'(cap_ferr_a), 0);
      chk("a5_ovr",   32'(ovr_a), 0);
      chk("a5_busy",  32'(busy_a), 0);

      // 60-clock glitch: busy latency, then false-start rejection
      v0 = vcyc_a;
      rx_a = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("lat_busy2", 32'(busy_a), 0);
      @(posedge clk); #1;
      chk("lat_busy3", 32'(busy_a), 1);
      repeat (57) @(negedge clk);
      rx_a = 1'b1;
      repeat (200) @(negedge clk);
      chk("glitch_busy",  32'(busy_a), 0);
      chk("glitch_valid", vcyc_a - v0, 0);

      // Back-to-back 0x11, 0x22 with ready low
      ready_a = 1'b0;
      send_frame(0, 8'h11, 8, 1'b0, 1'b0, 1, 2'b11);
      send_frame(0, 8'h22, 8, 1'b0, 1'b0, 1, 2'b11);
      repeat (40) @(negedge clk);
      chk("ovr_valid", 32'(valid_a), 1);
      chk("ovr_data",  32'(data_out_a), 32'h11);
      chk("ovr_flag",  32'(ovr_a), 1);
      chk("ovr_ferr",  32'(ferr_a), 0);
      ready_a = 1'b1;
      @(posedge clk); #1;
      chk("ovr_drop",   32'(valid_a), 0);
      chk("ovr_sticky", 32'(ovr_a), 1);

      // Reset during data bit 4 of 0x0F, then 0xF0
      @(negedge clk);
      n0 = cap_cnt_a;
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
      rx_a = 1'b0;
      repeat (80) @(negedge clk);
      chk("mid_busy_pre", 32'(busy_a), 1);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_rst_data",  32'(data_out_a), 0);
      chk("mid_rst_valid", 32'(valid_a), 0);
      chk("mid_rst_perr",  32'(perr_a), 0);
      chk("mid_rst_ferr",  32'(ferr_a), 0);
      chk("mid_rst_ovr",   32'(ovr_a), 0);
      chk("mid_rst_busy",  32'(busy_a), 0);
      rx_a = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      send_frame(0, 8'hF0, 8, 1'b0, 1'b0, 1, 2'b11);
      repeat (40) @(negedge clk);
      chk("f0_count", cap_cnt_a - n0, 1);
      chk("f0_data",  32'(cap_data_a), 32'hF0);
      chk("f0_ferr",  32'(cap_ferr_a), 0);
      chk("f0_ovr",   32'(ovr_a), 0);

      // 7E1 0x3C: correct parity bit 0, then wrong parity bit 1
      n0 = cap_cnt_b;
      send_frame(1, 8'h3C, 7, 1'b1, 1'b0, 1, 2'b11);
      repeat (40) @(negedge clk);
      chk("e1_count", cap_cnt_b - n0, 1);
      chk("e1_data",  32'(cap_data_b), 32'h3C);
      chk("e1_perr",  32'(cap_perr_b), 0);
      chk("e1_ferr",  32'(cap_ferr_b), 0);
      send_frame(1, 8'h3C, 7, 1'b1, 1'b1, 1, 2'b11);
      repeat (40) @(negedge clk);
      chk("e1bad_count", cap_cnt_b - n0, 2);
      chk("e1bad_data",  32'(cap_data_b), 32'h3C);
      chk("e1bad_perr",  32'(cap_perr_b), 1);
      chk("e1bad_ferr",  32'(cap_ferr_b), 0);

      // 8N2 0xC3 with second stop low: frame error and break wait
      n0 = cap_cnt_c;
      send_frame(2, 8'hC3, 8, 1'b0, 1'b0, 2, 2'b01);
      chk("brk_busy0", 32'(busy_c), 1);
      chk("brk_count", cap_cnt_c - n0, 1);
      chk("brk_data",  32'(cap_data_c), 32'hC3);
      chk("brk_ferr",  32'(cap_ferr_c), 1);
      chk("brk_perr",  32'(cap_perr_c), 0);
      repeat (100) @(negedge clk);
      chk("brk_wait_busy", 32'(busy_c), 1);
      repeat (120) @(negedge clk);
      chk("brk_idle_busy", 32'(busy_c), 0);
      send_frame(2, 8'h55, 8, 1'b0, 1'b0, 2, 2'b11);
      repeat (40) @(negedge clk);
      chk("n2_count", cap_cnt_c - n0, 2);
      chk("n2_data",  32'(cap_data_c), 32'h55);
      chk("n2_ferr",  32'(cap_ferr_c), 0);
      chk("n2_busy",  32'(busy_c), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
